param_queue: RTL and testbench

PARAM_QUEUE -- requirements
Module: param_queue

---
 rtl/param_queue_pkg.sv | 13 +
 rtl/param_queue_if.sv | 35 +++
 rtl/queue_req_sync.sv | 22 ++
 rtl/param_queue.sv | 129 ++++++++++++
 tb/tb_param_queue.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/param_queue_pkg.sv
// Shared types and default sizes for the param_queue block.
package param_queue_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic [1:0] {
    ENQ_IDLE     = 2'd0,
    ENQ_ACK      = 2'd1,
    ENQ_WAIT_LOW = 2'd2
  } enq_state_t;

endpackage

// File: rtl/param_queue_if.sv
// Producer/consumer bundle of the param_queue block; the queue is the slave side.
interface param_queue_if
  import param_queue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] data_in;
  logic              enqueue_in;
  logic              ack_out;
  logic              dequeue_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [LEN_W-1:0]  len_out;
  logic              full_out;
  logic              empty_out;
  logic              afull_out;
  logic              overflow_out;
  logic              underflow_out;

  modport master (
    output data_in, enqueue_in, dequeue_in,
    input  ack_out, data_out, valid_out, len_out,
           full_out, empty_out, afull_out, overflow_out, underflow_out
  );

  modport slave (
    input  data_in, enqueue_in, dequeue_in,
    output ack_out, data_out, valid_out, len_out,
           full_out, empty_out, afull_out, overflow_out, underflow_out
  );

endinterface

// File: rtl/queue_req_sync.sv
// Two-flop synchronizer bringing the foreign-clock enqueue request into clk_10khz.
module queue_req_sync (
  input  logic clk_10khz,
  input  logic queue_rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample pre-edge values.
  always_ff @(posedge clk_10khz or posedge queue_rst) begin
    if (queue_rst) begin
      meta_q   <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/param_queue.sv
// Parameterised queue with a synchronized level/ack enqueue handshake and pulsed pops.
// Define PARAM_QUEUE_DROP_EN to ack and discard requests made while full instead of stalling.
module param_queue
  import param_queue_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic         clk_10khz,
  input  logic         queue_rst,
  param_queue_if.slave q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] AFULL_L = LEN_W'(AFULL_LVL);

  enq_state_t        state_q, state_d;
  logic              enq_s;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              full_q, empty_q, afull_q;
  logic              valid_q, udf_q;
  logic [DATA_W-1:0] dout_q;
`ifdef PARAM_QUEUE_DROP_EN
  logic              drop_d;
  logic              ovf_q;
`endif

  queue_req_sync u_req_sync (
    .clk_10khz (clk_10khz),
    .queue_rst (queue_rst),
    .async_in  (q.enqueue_in),
    .sync_out  (enq_s)
  );

  always_ff @(posedge clk_10khz or posedge queue_rst) begin
    if (queue_rst) state_q <= ENQ_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no branch can infer a latch.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
`ifdef PARAM_QUEUE_DROP_EN
    drop_d  = 1'b0;
`endif
    case (state_q)
      ENQ_IDLE: begin
        if (enq_s) begin
          if (!full_q) begin
            wr_en   = 1'b1;
            state_d = ENQ_ACK;
          end else begin
`ifdef PARAM_QUEUE_DROP_EN
            drop_d  = 1'b1;
            state_d = ENQ_ACK;
`else
            state_d = ENQ_IDLE;
`endif
          end
        end
      end
      ENQ_ACK:      state_d = ENQ_WAIT_LOW;
      ENQ_WAIT_LOW: if (!enq_s) state_d = ENQ_IDLE;
      default:      state_d = ENQ_IDLE;
    endcase
  end

  // Flags come from pre-edge occupancy: a pop never makes room for a same-edge write.
  assign rd_en = q.dequeue_in && !empty_q;
  assign len_d = len_q + LEN_W'(wr_en) - LEN_W'(rd_en);

  // NOTE: storage is deliberately left out of reset; only pointers and occupancy define validity.
  always_ff @(posedge clk_10khz) begin
    if (wr_en) mem[wr_ptr_q] <= q.data_in;
  end

  always_ff @(posedge clk_10khz or posedge queue_rst) begin
    if (queue_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
      udf_q    <= 1'b0;
    end else begin
      len_q   <= len_d;
      full_q  <= (len_d == DEPTH_L);
      empty_q <= (len_d == '0);
      afull_q <= (len_d >= AFULL_L);
      valid_q <= rd_en;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) begin
        dout_q   <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (q.dequeue_in && empty_q) udf_q <= 1'b1;
    end
  end

`ifdef PARAM_QUEUE_DROP_EN
  always_ff @(posedge clk_10khz or posedge queue_rst) begin
    if (queue_rst)   ovf_q <= 1'b0;
    else if (drop_d) ovf_q <= 1'b1;
  end
  assign q.overflow_out = ovf_q;
`else
  assign q.overflow_out = 1'b0;
`endif

  assign q.ack_out       = (state_q == ENQ_ACK);
  assign q.data_out      = dout_q;
  assign q.valid_out     = valid_q;
  assign q.len_out       = len_q;
  assign q.full_out      = full_q;
  assign q.empty_out     = empty_q;
  assign q.afull_out     = afull_q;
  assign q.underflow_out = udf_q;

endmodule

// File: tb/tb_param_queue.sv
// Directed bench for param_queue: queue-based reference model checked every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_param_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AFULL  = DEPTH - 2;
`ifdef PARAM_QUEUE_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk_10khz = 1'b0;
  logic queue_rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk_10khz = ~clk_10khz;

  param_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) q_if ();

  param_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk_10khz (clk_10khz),
    .queue_rst (queue_rst),
    .q         (q_if.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus the handshake rule "two edges of sync delay,
  // one acceptance per request, re-armed after the request is seen low".
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_dout;
  bit m_s1, m_s2, m_armed, m_ack, m_valid, m_udf, m_ovf;
  bit m_wr, m_rd, m_drop;
  int m_pre;

  always @(posedge clk_10khz or posedge queue_rst) begin
    if (queue_rst) begin
      m_q.delete();
      m_dout = '0;
      m_s1 = 0; m_s2 = 0; m_armed = 1; m_ack = 0;
      m_valid = 0; m_udf = 0; m_ovf = 0;
    end else begin
      m_pre  = m_q.size();
      m_wr   = m_armed && m_s2 && (m_pre < DEPTH);
      m_drop = DROP && m_armed && m_s2 && (m_pre == DEPTH);
      m_rd   = q_if.dequeue_in && (m_pre > 0);
      if (q_if.dequeue_in && m_pre == 0) m_udf = 1;
      if (m_rd) m_dout = m_q.pop_front();
      m_valid = m_rd;
      if (m_wr) m_q.push_back(q_if.data_in);
      if (m_drop) m_ovf = 1;
      if (!m_armed && !m_ack && !m_s2) m_armed = 1;
      m_ack = m_wr || m_drop;
      if (m_ack) m_armed = 0;
      m_s2 = m_s1;
      m_s1 = q_if.enqueue_in;
    end
  end

  always @(negedge clk_10khz) begin
    check("ack_out",       q_if.ack_out,       m_ack);
    check("valid_out",     q_if.valid_out,     m_valid);
    check("data_out",      q_if.data_out,      m_dout);
    check("len_out",       q_if.len_out,       m_q.size());
    check("full_out",      q_if.full_out,      m_q.size() == DEPTH);
    check("empty_out",     q_if.empty_out,     m_q.size() == 0);
    check("afull_out",     q_if.afull_out,     m_q.size() >= AFULL);
    check("underflow_out", q_if.underflow_out, m_udf);
    check("overflow_out",  q_if.overflow_out,  m_ovf);
  end

  task automatic cycle();
    @(posedge clk_10khz);
    #1;
  endtask

  task automatic apply_reset();
    queue_rst = 1'b1;
    repeat (2) cycle();
    queue_rst = 1'b0;
  endtask

  task automatic wait_ack(input int max, output bit seen);
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      cycle();
      if (q_if.ack_out) seen = 1;
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    bit seen;
    q_if.data_in    = d;
    q_if.enqueue_in = 1'b1;
    wait_ack(8, seen);
    check("push_ack_seen", seen, 1);
    q_if.enqueue_in = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic pop();
    q_if.dequeue_in = 1'b1;
    cycle();
    q_if.dequeue_in = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int acks;
    logic [DATA_W-1:0] last;

    q_if.data_in    = '0;
    q_if.enqueue_in = 1'b0;
    q_if.dequeue_in = 1'b0;
    queue_rst       = 1'b0;
    #1;
    apply_reset();
    check("rst_len", q_if.len_out, 0);
    check("rst_empty", q_if.empty_out, 1);
    check("rst_ack", q_if.ack_out, 0);

    // Single enqueue: ack exactly at E+2, gone at E+3.
    q_if.data_in    = 8'hA5;
    q_if.enqueue_in = 1'b1;
    cycle(); check("t1_ack_e0", q_if.ack_out, 0);
    cycle(); check("t1_ack_e1", q_if.ack_out, 0);
    check("t1_len_e1", q_if.len_out, 0);
    cycle(); check("t1_ack_e2", q_if.ack_out, 1);
    check("t1_len_e2", q_if.len_out, 1);
    check("t1_empty_e2", q_if.empty_out, 0);
    cycle(); check("t1_ack_e3", q_if.ack_out, 0);
    q_if.enqueue_in = 1'b0;
    repeat (3) cycle();
    pop();
    check("t1_pop_valid", q_if.valid_out, 1);
    check("t1_pop_data", q_if.data_out, 8'hA5);
    check("t1_pop_empty", q_if.empty_out, 1);
    cycle(); check("t1_valid_fall", q_if.valid_out, 0);

    // Long-held request yields one write and one ack.
    q_if.data_in    = 8'h5A;
    q_if.enqueue_in = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (q_if.ack_out) acks++;
    end
    q_if.enqueue_in = 1'b0;
    repeat (3) cycle();
    check("t2_ack_count", acks, 1);
    check("t2_len", q_if.len_out, 1);
    pop();
    check("t2_data", q_if.data_out, 8'h5A);

    // Full queue: stall or drop on the 9th request.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i));
    check("t3_len_full", q_if.len_out, 8);
    check("t3_full", q_if.full_out, 1);
    check("t3_afull", q_if.afull_out, 1);
    q_if.data_in    = 8'h99;
    q_if.enqueue_in = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (q_if.ack_out) acks++;
    end
    check("t3_ninth_acks", acks, DROP ? 1 : 0);
    check("t3_len_after_req", q_if.len_out, 8);
    check("t3_overflow", q_if.overflow_out, DROP ? 1 : 0);
    if (DROP) begin
      q_if.enqueue_in = 1'b0;
      repeat (3) cycle();
      pop();
      check("t3_pop_data", q_if.data_out, 8'h10);
      check("t3_len_drop", q_if.len_out, 7);
    end else begin
      pop();
      check("t3_pop_data", q_if.data_out, 8'h10);
      wait_ack(10, seen);
      check("t3_stall_acked", seen, 1);
      check("t3_len_stall", q_if.len_out, 8);
      q_if.enqueue_in = 1'b0;
      repeat (3) cycle();
    end
    last = '0;
    for (int i = 0; i < 12 && !q_if.empty_out; i++) begin
      pop();
      last = q_if.data_out;
    end
    check("t3_last_word", last, DROP ? 8'h17 : 8'h99);
    check("t3_drained", q_if.empty_out, 1);

    // Wrap-around ordering and underflow.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) push(8'h20 + 8'(i));
    for (int i = 0; i < DEPTH; i++) begin
      pop();
      check("t4_order", q_if.data_out, 8'h20 + 8'(i));
    end
    check("t4_empty", q_if.empty_out, 1);
    push(8'hE1);
    push(8'hE2);
    pop(); check("t4_wrap0", q_if.data_out, 8'hE1);
    pop(); check("t4_wrap1", q_if.data_out, 8'hE2);
    pop();
    check("t4_udf_valid", q_if.valid_out, 0);
    check("t4_udf_hold", q_if.data_out, 8'hE2);
    check("t4_udf_flag", q_if.underflow_out, 1);

    // Simultaneous write and pop at len 3.
    apply_reset();
    push(8'h31); push(8'h32); push(8'h33);
    q_if.data_in    = 8'h34;
    q_if.enqueue_in = 1'b1;
    cycle(); cycle();
    q_if.dequeue_in = 1'b1;
    cycle();
    q_if.dequeue_in = 1'b0;
    check("t5_ack", q_if.ack_out, 1);
    check("t5_len", q_if.len_out, 3);
    check("t5_valid", q_if.valid_out, 1);
    check("t5_data", q_if.data_out, 8'h31);
    q_if.enqueue_in = 1'b0;
    repeat (3) cycle();

    // Reset while in ENQ_ACK with the request still held.
    apply_reset();
    q_if.data_in    = 8'h3C;
    q_if.enqueue_in = 1'b1;
    wait_ack(8, seen);
    check("t6_in_ack", seen, 1);
    #1 queue_rst = 1'b1;
    #1;
    check("t6_rst_ack", q_if.ack_out, 0);
    check("t6_rst_len", q_if.len_out, 0);
    check("t6_rst_empty", q_if.empty_out, 1);
    check("t6_rst_data", q_if.data_out, 0);
    cycle(); cycle();
    queue_rst = 1'b0;
    cycle(); check("t6_ack_e0", q_if.ack_out, 0);
    cycle(); check("t6_ack_e1", q_if.ack_out, 0);
    cycle(); check("t6_ack_e2", q_if.ack_out, 1);
    check("t6_len", q_if.len_out, 1);
    q_if.enqueue_in = 1'b0;
    repeat (3) cycle();
    pop();
    check("t6_data", q_if.data_out, 8'h3C);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
